// File: rtl/sub16sat_seq_pkg.sv
// Shared types and widths for the saturating step-down sequencer.
// Imported by the arithmetic cell and by the top level.
package sub16sat_seq_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_sub_cell.sv
// Combinational subtract with optional clamp-at-zero on borrow.
// In eightbit mode only the low byte is stepped; the high byte passes through.
module sat_sub_cell
  import sub16sat_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sat,
  input  logic              eightbit,
  output logic [DATA_W-1:0] z,
  output logic              borrow
);

  logic [DATA_W:0]   diff_w;
  logic [BYTE_W:0]   diff_b;
  logic [BYTE_W-1:0] low_byte;

  always_comb begin
    diff_w   = {1'b0, a} - {1'b0, b};
    diff_b   = {1'b0, a[BYTE_W-1:0]} - {1'b0, b[BYTE_W-1:0]};
    low_byte = '0;
    if (eightbit) begin
      // The byte borrow never propagates into bit 8.
      borrow   = diff_b[BYTE_W];
      low_byte = (borrow && sat) ? {BYTE_W{1'b0}} : diff_b[BYTE_W-1:0];
      z        = {a[DATA_W-1:BYTE_W], low_byte};
    end else begin
      borrow = diff_w[DATA_W];
      z      = (borrow && sat) ? {DATA_W{1'b0}} : diff_w[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/sub16sat_seq.sv
// Runs count successive subtractions of step from init, emitting each result
// through a valid/ready slot; done pulses for one cycle when the run ends.
module sub16sat_seq
  import sub16sat_seq_pkg::*;
(
  input  logic              clk,
  input  logic              resetl,
  input  logic              start,
  input  logic [DATA_W-1:0] init,
  input  logic [DATA_W-1:0] step,
  input  logic [CNT_W-1:0]  count,
  input  logic              sat,
  input  logic              eightbit,
  input  logic              out_ready,
  output logic [DATA_W-1:0] r,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              uflow
);

  localparam logic [CNT_W-1:0] ONE_CNT = 1;

  state_t            state, state_next;
  logic [DATA_W-1:0] acc, step_q, next_val;
  logic [CNT_W-1:0]  rem;
  logic              sat_q, eightbit_q, borrow;
  logic              accept_start, produce, final_accept;

  sat_sub_cell u_cell (
    .a        (acc),
    .b        (step_q),
    .sat      (sat_q),
    .eightbit (eightbit_q),
    .z        (next_val),
    .borrow   (borrow)
  );

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    produce      = 1'b0;
    final_accept = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = (count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // The run ends only once the last result has actually been taken.
        if (out_valid && out_ready && rem == '0) begin
          final_accept = 1'b1;
          state_next   = ST_DONE;
        end else if (rem != '0 && (!out_valid || out_ready)) begin
          produce = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      acc        <= '0;
      step_q     <= '0;
      rem        <= '0;
      sat_q      <= 1'b0;
      eightbit_q <= 1'b0;
      r          <= '0;
      out_valid  <= 1'b0;
      uflow      <= 1'b0;
    end else begin
      if (accept_start) begin
        acc        <= init;
        step_q     <= step;
        rem        <= count;
        sat_q      <= sat;
        eightbit_q <= eightbit;
        uflow      <= 1'b0;
      end
      if (produce) begin
        acc       <= next_val;
        r         <= next_val;
        out_valid <= 1'b1;
        rem       <= rem - ONE_CNT;
        if (borrow) uflow <= 1'b1;
      end else if (final_accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sub16sat_seq.sv
// Directed self-checking bench for sub16sat_seq: reset, sat/wrap/eightbit runs,
// back-pressure, count boundaries, ignored starts and mid-run reset.
module tb_sub16sat_seq;

  logic        clk = 1'b0;
  logic        resetl;
  logic        start;
  logic [15:0] init;
  logic [15:0] step;
  logic [7:0]  count;
  logic        sat;
  logic        eightbit;
  logic        out_ready;
  logic [15:0] r;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        uflow;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] res [0:299];
  int          n_res;
  int          last_acc_cyc;
  int          done_cyc;
  bit          timed_out;
  logic        uflow_done;

  sub16sat_seq dut (
    .clk       (clk),
    .resetl    (resetl),
    .start     (start),
    .init      (init),
    .step      (step),
    .count     (count),
    .sat       (sat),
    .eightbit  (eightbit),
    .out_ready (out_ready),
    .r         (r),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .uflow     (uflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Starts a run with out_ready held high and records every accepted result.
  // With junk_start, start stays high with different operands inside RUN.
  task automatic run_and_collect(input logic [15:0] i_init, input logic [15:0] i_step,
                                 input logic [7:0] i_count, input logic i_sat,
                                 input logic i_eb, input bit junk_start);
    n_res = 0; last_acc_cyc = -1; done_cyc = -1; timed_out = 1'b1; uflow_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; init = i_init; step = i_step; count = i_count;
    sat = i_sat; eightbit = i_eb; out_ready = 1'b1;
    @(posedge clk); #1;
    if (junk_start) begin
      init = 16'hFFFF; step = 16'h1000; count = 8'd200; sat = 1'b0; eightbit = 1'b1;
    end else begin
      start = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (n_res < 300) res[n_res] = r;
        n_res++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc; uflow_done = uflow; timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (cyc == 2) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetl = 1'b0; start = 1'b0; init = '0; step = '0; count = '0;
    sat = 1'b0; eightbit = 1'b0; out_ready = 1'b0;
    #12;
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_r: got %h expected 0000", r); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (uflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_uflow: got %b expected 0", uflow); end
    @(negedge clk);
    resetl = 1'b1;
  endtask

  task automatic test_sat_mode();
    logic [15:0] exp_r [0:4];
    exp_r = '{16'h00C0, 16'h0080, 16'h0040, 16'h0000, 16'h0000};
    run_and_collect(16'h0100, 16'h0040, 8'd5, 1'b1, 1'b0, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_timeout: got done=%b expected done within budget", !timed_out); end
    n_checks++; if (n_res !== 5) begin n_fail++; $display("[TB] FAIL sat_count: got %0d expected 5", n_res); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (res[i] !== exp_r[i]) begin n_fail++; $display("[TB] FAIL sat_r%0d: got %h expected %h", i, res[i], exp_r[i]); end
    end
    n_checks++; if (uflow_done !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_uflow: got %b expected 1", uflow_done); end
    n_checks++; if (done_cyc !== last_acc_cyc + 1) begin n_fail++; $display("[TB] FAIL sat_done_timing: got cycle %0d expected %0d", done_cyc, last_acc_cyc + 1); end
  endtask

  task automatic test_wrap_mode();
    logic [15:0] exp_r [0:4];
    exp_r = '{16'h00C0, 16'h0080, 16'h0040, 16'h0000, 16'hFFC0};
    run_and_collect(16'h0100, 16'h0040, 8'd5, 1'b0, 1'b0, 1'b0);
    n_checks++; if (n_res !== 5) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 5", n_res); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (res[i] !== exp_r[i]) begin n_fail++; $display("[TB] FAIL wrap_r%0d: got %h expected %h", i, res[i], exp_r[i]); end
    end
    n_checks++; if (uflow_done !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_uflow: got %b expected 1", uflow_done); end
  endtask

  task automatic test_eightbit();
    logic [15:0] exp_r [0:2];
    exp_r = '{16'hAB02, 16'hAB00, 16'hAB00};
    run_and_collect(16'hAB05, 16'h0003, 8'd3, 1'b1, 1'b1, 1'b0);
    n_checks++; if (n_res !== 3) begin n_fail++; $display("[TB] FAIL eb_count: got %0d expected 3", n_res); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (res[i] !== exp_r[i]) begin n_fail++; $display("[TB] FAIL eb_r%0d: got %h expected %h", i, res[i], exp_r[i]); end
    end
    n_checks++; if (uflow_done !== 1'b1) begin n_fail++; $display("[TB] FAIL eb_uflow: got %b expected 1", uflow_done); end
  endtask

  task automatic test_step_zero_max_count();
    int bad;
    bad = 0;
    run_and_collect(16'h1234, 16'h0000, 8'd255, 1'b0, 1'b0, 1'b0);
    n_checks++; if (n_res !== 255) begin n_fail++; $display("[TB] FAIL max_count: got %0d expected 255", n_res); end
    for (int i = 0; i < 255 && i < n_res; i++) begin
      n_checks++; if (res[i] !== 16'h1234) begin n_fail++; $display("[TB] FAIL step0_r%0d: got %h expected 1234", i, res[i]); end
    end
    n_checks++; if (uflow_done !== 1'b0) begin n_fail++; $display("[TB] FAIL step0_uflow: got %b expected 0", uflow_done); end
  endtask

  task automatic test_count_zero_and_ignore();
    @(posedge clk); #1;
    start = 1'b1; init = 16'h5555; step = 16'h0001; count = 8'd0;
    sat = 1'b0; eightbit = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    count = 8'd3;
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL cnt0_done: got %b expected 1", done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL cnt0_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cnt0_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL cnt0_done_pulse: got %b expected 0", done); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL done_start_ignored: got busy %b expected 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL done_start_valid: got %b expected 0", out_valid); end
    run_and_collect(16'h0010, 16'h0001, 8'd3, 1'b0, 1'b0, 1'b1);
    n_checks++; if (n_res !== 3) begin n_fail++; $display("[TB] FAIL run_start_count: got %0d expected 3", n_res); end
    n_checks++; if (res[0] !== 16'h000F) begin n_fail++; $display("[TB] FAIL run_start_r0: got %h expected 000f", res[0]); end
    n_checks++; if (res[1] !== 16'h000E) begin n_fail++; $display("[TB] FAIL run_start_r1: got %h expected 000e", res[1]); end
    n_checks++; if (res[2] !== 16'h000D) begin n_fail++; $display("[TB] FAIL run_start_r2: got %h expected 000d", res[2]); end
    n_checks++; if (uflow_done !== 1'b0) begin n_fail++; $display("[TB] FAIL run_start_uflow: got %b expected 0", uflow_done); end
  endtask

  task automatic test_back_pressure();
    bit          found;
    bit          fin;
    int          got;
    logic [15:0] exp_r [0:2];
    exp_r = '{16'h00F0, 16'h00E0, 16'h00D0};
    found = 1'b0; fin = 1'b0; got = 0;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b1; init = 16'h0100; step = 16'h0010;
    count = 8'd3; sat = 1'b0; eightbit = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; break; end
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_first_valid: got %b expected 1", found); end
    n_checks++; if (r !== 16'h00F0) begin n_fail++; $display("[TB] FAIL bp_first_r: got %h expected 00f0", r); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (r !== 16'h00F0) begin n_fail++; $display("[TB] FAIL bp_hold_r%0d: got %h expected 00f0", c, r); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_valid%0d: got %b expected 1", c, out_valid); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_busy%0d: got %b expected 1", c, busy); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (got < 3) begin
          n_checks++; if (r !== exp_r[got]) begin n_fail++; $display("[TB] FAIL bp_r%0d: got %h expected %h", got, r, exp_r[got]); end
        end
        got++;
      end
      if (done) begin fin = 1'b1; break; end
    end
    n_checks++; if (fin !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_done: got %b expected 1", fin); end
    n_checks++; if (got !== 3) begin n_fail++; $display("[TB] FAIL bp_accepted: got %0d expected 3", got); end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    out_ready = 1'b1; start = 1'b1; init = 16'h0005; step = 16'h0001;
    count = 8'd10; sat = 1'b1; eightbit = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    n_checks++; if (uflow !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_uflow_before: got %b expected 1", uflow); end
    #2;
    resetl = 1'b0;
    #1;
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_reset_r: got %h expected 0000", r); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_done: got %b expected 0", done); end
    n_checks++; if (uflow !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_uflow: got %b expected 0", uflow); end
    @(negedge clk);
    resetl = 1'b1;
    run_and_collect(16'h0030, 16'h0010, 8'd3, 1'b0, 1'b0, 1'b0);
    n_checks++; if (n_res !== 3) begin n_fail++; $display("[TB] FAIL post_reset_count: got %0d expected 3", n_res); end
    n_checks++; if (res[0] !== 16'h0020) begin n_fail++; $display("[TB] FAIL post_reset_r0: got %h expected 0020", res[0]); end
    n_checks++; if (res[1] !== 16'h0010) begin n_fail++; $display("[TB] FAIL post_reset_r1: got %h expected 0010", res[1]); end
    n_checks++; if (res[2] !== 16'h0000) begin n_fail++; $display("[TB] FAIL post_reset_r2: got %h expected 0000", res[2]); end
    n_checks++; if (uflow_done !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_uflow: got %b expected 0", uflow_done); end
  endtask

  initial begin
    test_reset();
    test_sat_mode();
    test_wrap_mode();
    test_eightbit();
    test_step_zero_max_count();
    test_count_zero_and_ignore();
    test_back_pressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
